// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps key press/release events onto NUM_VOICES voice
// datapaths, reusing a voice already playing the note, else a free one, else the oldest.
module voice_allocator #(
   parameter int NUM_VOICES = 4,
   parameter int AGE_W      = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    key_valid,
   output logic                    key_ready,
   input  logic                    key_on,
   input  logic [3:0]              key_note,
   input  logic [2:0]              key_octave,
   input  logic                    all_off,
   output logic [4*NUM_VOICES-1:0] voice_note,
   output logic [3*NUM_VOICES-1:0] voice_octave,
   output logic [NUM_VOICES-1:0]   voice_ld,
   output logic [NUM_VOICES-1:0]   voice_play,
   output logic [1:0]              dbg_state
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

   typedef enum logic [1:0] {IDLE, SCAN, LOAD, REL} state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic                    r_on;
   logic [3:0]              r_note;
   logic [2:0]              r_oct;
   logic [IDX_W-1:0]        r_target;
   logic [4*NUM_VOICES-1:0] r_voice_note;
   logic [3*NUM_VOICES-1:0] r_voice_oct;
   logic [NUM_VOICES-1:0]   r_voice_ld;
   logic [NUM_VOICES-1:0]   r_voice_play;
   logic [AGE_W-1:0]        r_age [NUM_VOICES];

   logic                    w_accept;
   logic                    w_press_ok;
   logic                    w_match_hit;
   logic [IDX_W-1:0]        w_match_idx;
   logic                    w_free_hit;
   logic [IDX_W-1:0]        w_free_idx;
   logic                    w_old_hit;
   logic [IDX_W-1:0]        w_old_idx;
   logic [AGE_W-1:0]        w_old_age;
   logic [IDX_W-1:0]        w_target;

   // Handshake: an event transfers on a clk edge where key_valid && key_ready;
   // key_ready is high only in IDLE with no panic pending, and the event fields
   // must be stable while key_valid is high.
   assign key_ready    = (r_state == IDLE) && !all_off;
   assign w_accept     = key_valid && key_ready;
   assign w_press_ok   = r_on && (r_note <= 4'd11);
   assign voice_note   = r_voice_note;
   assign voice_octave = r_voice_oct;
   assign voice_ld     = r_voice_ld;
   assign voice_play   = r_voice_play;
   assign dbg_state    = r_state;

   // Candidate search: descending scans give lowest-index priority; strict '>'
   // on the ascending age scan keeps ties on the lowest index.
   always_comb begin
      w_match_hit = 1'b0;
      w_match_idx = '0;
      w_free_hit  = 1'b0;
      w_free_idx  = '0;
      w_old_hit   = 1'b0;
      w_old_idx   = '0;
      w_old_age   = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (r_voice_play[i] && (r_voice_note[4*i +: 4] == r_note) &&
             (r_voice_oct[3*i +: 3] == r_oct)) begin
            w_match_hit = 1'b1;
            w_match_idx = IDX_W'(i);
         end
         if (!r_voice_play[i]) begin
            w_free_hit = 1'b1;
            w_free_idx = IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (r_voice_play[i] && (!w_old_hit || (r_age[i] > w_old_age))) begin
            w_old_hit = 1'b1;
            w_old_idx = IDX_W'(i);
            w_old_age = r_age[i];
         end
      end
      if (w_match_hit)     w_target = w_match_idx;
      else if (w_free_hit) w_target = w_free_idx;
      else                 w_target = w_old_idx;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: if (w_accept) w_next_state = SCAN;
         SCAN: begin
            if (r_on) w_next_state = w_press_ok ? LOAD : IDLE;
            else      w_next_state = w_match_hit ? REL : IDLE;
         end
         LOAD:    w_next_state = IDLE;
         REL:     w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_on         <= 1'b0;
         r_note       <= '0;
         r_oct        <= '0;
         r_target     <= '0;
         r_voice_note <= '0;
         r_voice_oct  <= '0;
         r_voice_ld   <= '0;
         r_voice_play <= '0;
         for (int i = 0; i < NUM_VOICES; i++) r_age[i] <= '0;
      end else if (all_off) begin
         r_state      <= IDLE;
         r_voice_ld   <= '0;
         r_voice_play <= '0;
         for (int i = 0; i < NUM_VOICES; i++) r_age[i] <= '0;
      end else begin
         r_state    <= w_next_state;
         r_voice_ld <= '0;
         if (r_state == IDLE && w_accept) begin
            r_on   <= key_on;
            r_note <= key_note;
            r_oct  <= key_octave;
         end
         if (r_state == SCAN) begin
            if (w_press_ok) begin
               r_target <= w_target;
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (IDX_W'(i) == w_target) begin
                     r_voice_note[4*i +: 4] <= r_note;
                     r_voice_oct[3*i +: 3]  <= r_oct;
                     r_voice_ld[i]          <= 1'b1;
                  end
               end
            end else if (!r_on) begin
               r_target <= w_match_idx;
            end
         end
         // A retriggered or stolen voice was already playing, so its gate never drops.
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (r_state == LOAD) begin
               if (IDX_W'(i) == r_target) begin
                  r_voice_play[i] <= 1'b1;
                  r_age[i]        <= '0;
               end else if (r_voice_play[i] && (r_age[i] != AGE_MAX)) begin
                  r_age[i] <= r_age[i] + AGE_W'(1);
               end
            end else if (r_state == REL && IDX_W'(i) == r_target) begin
               r_voice_play[i] <= 1'b0;
               r_age[i]        <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: expected load events are queued by the driver
// and popped by a monitor whenever a voice_ld strobe appears.
module tb_voice_allocator;

   localparam int NV = 4;
   localparam int W  = NV + 4 + 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          key_valid = 1'b0;
   logic          key_ready;
   logic          key_on = 1'b0;
   logic [3:0]    key_note = '0;
   logic [2:0]    key_octave = '0;
   logic          all_off = 1'b0;
   logic [4*NV-1:0] voice_note;
   logic [3*NV-1:0] voice_octave;
   logic [NV-1:0] voice_ld;
   logic [NV-1:0] voice_play;
   logic [1:0]    dbg_state;

   logic [W-1:0]  exp_q[$];
   int            checks = 0;
   int            failures = 0;
   int            mon_idx;
   logic [W-1:0]  mon_act;
   logic [W-1:0]  mon_exp;

   voice_allocator #(.NUM_VOICES(NV), .AGE_W(3)) dut (
      .clk(clk), .reset(reset), .key_valid(key_valid), .key_ready(key_ready),
      .key_on(key_on), .key_note(key_note), .key_octave(key_octave), .all_off(all_off),
      .voice_note(voice_note), .voice_octave(voice_octave), .voice_ld(voice_ld),
      .voice_play(voice_play), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: every load strobe must match the next queued expectation.
   always @(negedge clk) begin
      if (!reset && voice_ld != '0) begin
         mon_idx = 0;
         for (int i = NV - 1; i >= 0; i--) if (voice_ld[i]) mon_idx = i;
         mon_act = {voice_ld, voice_note[4*mon_idx +: 4], voice_octave[3*mon_idx +: 3]};
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ld actual=%0h expected=none", mon_act);
         end else begin
            mon_exp = exp_q.pop_front();
            check("ld_event", {21'd0, mon_act}, {21'd0, mon_exp});
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      key_valid = 1'b0;
      all_off = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!key_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!key_ready) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=ready_low expected=ready_high", name);
      end
   endtask

   // Returns at the negedge of the cycle following acceptance (the SCAN cycle).
   task automatic send(input logic on, input logic [3:0] n, input logic [2:0] o);
      wait_ready("send");
      key_valid  = 1'b1;
      key_on     = on;
      key_note   = n;
      key_octave = o;
      @(negedge clk);
      key_valid  = 1'b0;
   endtask

   task automatic press(input logic [3:0] n, input logic [2:0] o, input logic [NV-1:0] exp_ld);
      exp_q.push_back({exp_ld, n, o});
      send(1'b1, n, o);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state and single-press latency
      do_reset();
      check("rst_ready", key_ready, 1);
      check("rst_play", voice_play, 0);
      check("rst_ld", voice_ld, 0);
      check("rst_note", voice_note, 0);
      check("rst_oct", voice_octave, 0);
      check("rst_state", dbg_state, 0);
      press(4'd9, 3'd4, 4'b0001);
      check("lat_scan_ready", key_ready, 0);
      check("lat_scan_ld", voice_ld, 0);
      @(negedge clk);
      check("lat_load_ready", key_ready, 0);
      check("lat_load_ld", voice_ld, 4'b0001);
      check("lat_load_note", voice_note[3:0], 9);
      check("lat_load_oct", voice_octave[2:0], 4);
      check("lat_load_play", voice_play, 0);
      @(negedge clk);
      check("lat_play", voice_play, 4'b0001);
      check("lat_ready_back", key_ready, 1);
      check("lat_ld_clear", voice_ld, 0);

      // Fill all voices, then steal oldest twice
      do_reset();
      press(4'd0, 3'd4, 4'b0001);
      press(4'd2, 3'd4, 4'b0010);
      press(4'd4, 3'd4, 4'b0100);
      press(4'd7, 3'd4, 4'b1000);
      wait_ready("fill");
      check("fill_play", voice_play, 4'b1111);
      press(4'd11, 3'd4, 4'b0001);
      check("steal_play_scan", voice_play, 4'b1111);
      @(negedge clk);
      check("steal_play_load", voice_play, 4'b1111);
      @(negedge clk);
      check("steal_play_after", voice_play, 4'b1111);
      check("steal_note", voice_note[3:0], 11);
      press(4'd1, 3'd4, 4'b0010);
      wait_ready("steal2");
      check("steal2_note", voice_note[7:4], 1);
      check("steal2_play", voice_play, 4'b1111);

      // Retrigger same note
      do_reset();
      press(4'd5, 3'd3, 4'b0001);
      press(4'd5, 3'd3, 4'b0001);
      wait_ready("retrig");
      check("retrig_play", voice_play, 4'b0001);

      // Release then reuse of the freed voice; release of unplayed note ignored
      do_reset();
      press(4'd0, 3'd4, 4'b0001);
      press(4'd2, 3'd4, 4'b0010);
      wait_ready("rel_a");
      check("rel_play_before", voice_play, 4'b0011);
      send(1'b0, 4'd0, 3'd4);
      wait_ready("rel_b");
      check("rel_play_after", voice_play, 4'b0010);
      press(4'd7, 3'd4, 4'b0001);
      wait_ready("rel_c");
      check("reuse_play", voice_play, 4'b0011);
      check("reuse_note", voice_note[3:0], 7);
      send(1'b0, 4'd3, 3'd4);
      wait_ready("rel_d");
      check("rel_unplayed_play", voice_play, 4'b0011);
      check("rel_unplayed_note", voice_note[7:0], 8'h27);

      // Out-of-range note dropped
      send(1'b1, 4'd13, 3'd4);
      check("bad_note_scan_ready", key_ready, 0);
      @(negedge clk);
      check("bad_note_ready", key_ready, 1);
      check("bad_note_play", voice_play, 4'b0011);
      check("bad_note_state", dbg_state, 0);

      // all_off during LOAD of a 3-voice chord
      do_reset();
      press(4'd0, 3'd4, 4'b0001);
      press(4'd4, 3'd4, 4'b0010);
      press(4'd7, 3'd4, 4'b0100);
      @(negedge clk);
      all_off = 1'b1;
      @(negedge clk);
      all_off = 1'b0;
      #1;
      check("alloff_play", voice_play, 0);
      check("alloff_ld", voice_ld, 0);
      check("alloff_ready", key_ready, 1);
      check("alloff_state", dbg_state, 0);

      // key_valid coincident with all_off is not accepted
      @(negedge clk);
      all_off = 1'b1;
      key_valid = 1'b1;
      key_on = 1'b1;
      key_note = 4'd2;
      key_octave = 3'd4;
      @(negedge clk);
      all_off = 1'b0;
      key_valid = 1'b0;
      #1;
      check("alloff_key_state", dbg_state, 0);
      check("alloff_key_ready", key_ready, 1);
      repeat (2) @(negedge clk);
      check("alloff_key_play", voice_play, 0);

      // Reset mid-SCAN discards the event
      press(4'd0, 3'd4, 4'b0001);
      send(1'b1, 4'd2, 3'd4);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_play", voice_play, 0);
      check("midrst_ld", voice_ld, 0);
      check("midrst_ready", key_ready, 1);
      check("midrst_note", voice_note, 0);
      check("midrst_state", dbg_state, 0);

      repeat (4) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
